// File: rtl/lab6_pkg.sv
// -----------------------------------------------------------------------------
// lab6_pkg
//   Shared constants for the lab6 input-conditioning blocks.
//
//   DEBOUNCE_CYCLES_HW  : stability window for hardware builds
//                         (10 ms at a 100 MHz system clock).
//   DEBOUNCE_CYCLES_SIM : short stability window used in simulation.
//
//   The debounce filter state is implicit in its counter, so no typedefs
//   are needed here.
// -----------------------------------------------------------------------------
package lab6_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_HW  = 1_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

endpackage : lab6_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer bringing one asynchronous signal into the clk
//   domain. Shared by every asynchronous input path in the lab datapath.
//
//   Ports
//     clk : system clock, rising edge
//     rst : synchronous, active-high reset; clears both stages to 0
//     d   : asynchronous input
//     q   : synchronized output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;  // may go metastable; only ever feeds s2_q
    logic s2_q;

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples its inputs from before the edge;
    // with blocking assignments s2_q would see this edge's s1_q and the
    // two stages would collapse into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule : sync_2ff

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions one raw push-button / switch into a clean, clock-synchronous
//   level plus single-cycle rise and fall pulses. The raw input passes a
//   two-flop synchronizer, then a counter filter that only lets the level
//   change after the synchronized input has disagreed with it for
//   STABLE_CYCLES consecutive edges.
//
//   Parameters
//     STABLE_CYCLES : consecutive disagreeing cycles required before
//                     btn_level changes; must be >= 1. Hardware builds pass
//                     DEBOUNCE_CYCLES_HW.
//
//   Ports
//     clk       : system clock, rising edge
//     rst       : synchronous, active-high reset
//     btn_in    : raw asynchronous, possibly bouncing input
//     btn_level : debounced level (registered)
//     btn_rise  : one-cycle pulse on btn_level 0->1 (registered)
//     btn_fall  : one-cycle pulse on btn_level 1->0 (registered)
// -----------------------------------------------------------------------------
module btn_debounce
    import lab6_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int unsigned       CNT_W    = $clog2(STABLE_CYCLES + 1);
    // Count value on which the pending change is accepted.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             btn_sync;

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    // Filter: the counter runs only while btn_sync disagrees with the
    // debounced level. A single agreeing sample clears it, so bounce never
    // accumulates toward a change. The counter stops at CNT_LAST, which
    // means it can never wrap.
    // NOTE: every output of this always_comb gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (btn_sync != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_sync;
                rise_d  = btn_sync;
                fall_d  = ~btn_sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset takes priority over an expiring count, so no pulse can escape
    // on the edge that reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//   Directed bench for btn_debounce with STABLE_CYCLES = 4. Outputs are
//   compared as the vector {btn_level, btn_rise, btn_fall}, sampled 1 time
//   unit after each rising edge. Edge numbering in comments follows the
//   design description: edge 0 is the first edge after btn_in changes.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    int n_assert = 0;
    int n_fail   = 0;

    btn_debounce #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs set after a step are seen
    // at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] expected);
        logic [2:0] observed;
        observed = {btn_level, btn_rise, btn_fall};
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed {level,rise,fall}=%b expected %b",
                   tag, observed, expected);
        end
    endtask

    initial begin
        // ---- Reset held 3 cycles with btn_in high ----
        rst    = 1'b1;
        btn_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset_hold_%0d", i), 3'b000);
        end
        rst = 1'b0;
        // Edge 0 is the first edge with rst low; level rises at edge 5.
        for (int e = 0; e < 5; e++) begin
            step();
            chk($sformatf("post_reset_e%0d", e), 3'b000);
        end
        step(); chk("post_reset_rise_e5", 3'b110);
        step(); chk("post_reset_e6",      3'b100);

        // ---- Release: 1 -> 0, fall pulse at edge 5 ----
        btn_in = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step();
            chk($sformatf("release_e%0d", e), 3'b100);
        end
        step(); chk("release_fall_e5", 3'b001);
        step(); chk("release_e6",      3'b000);

        // ---- Glitch: high for 3 cycles only, never reaches 4 ----
        btn_in = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            chk($sformatf("glitch_hi_e%0d", e), 3'b000);
        end
        btn_in = 1'b0;
        for (int e = 3; e < 12; e++) begin
            step();
            chk($sformatf("glitch_lo_e%0d", e), 3'b000);
        end

        // ---- Clean press ----
        btn_in = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            chk($sformatf("press_e%0d", e), 3'b000);
        end
        step(); chk("press_rise_e5", 3'b110);
        step(); chk("press_e6",      3'b100);
        step(); chk("press_e7",      3'b100);

        // ---- Second release to return to level 0 ----
        btn_in = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step();
            chk($sformatf("release2_e%0d", e), 3'b100);
        end
        step(); chk("release2_fall_e5", 3'b001);
        step(); chk("release2_e6",      3'b000);

        // ---- Bounce: 1,0,1,0 before edges 0..3, then steady 1 ----
        // Final change lands before edge 4, so the level rises at edge 9.
        btn_in = 1'b1; step(); chk("bounce_e0", 3'b000);
        btn_in = 1'b0; step(); chk("bounce_e1", 3'b000);
        btn_in = 1'b1; step(); chk("bounce_e2", 3'b000);
        btn_in = 1'b0; step(); chk("bounce_e3", 3'b000);
        btn_in = 1'b1;
        for (int e = 4; e < 9; e++) begin
            step();
            chk($sformatf("bounce_e%0d", e), 3'b000);
        end
        step(); chk("bounce_rise_e9", 3'b110);
        step(); chk("bounce_e10",     3'b100);
        step(); chk("bounce_e11",     3'b100);

        // ---- Release with reset landing on the expiring edge ----
        // The count would expire at edge 5; reset on that edge wins and
        // no fall pulse appears afterwards.
        btn_in = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step();
            chk($sformatf("rst_expire_e%0d", e), 3'b100);
        end
        rst = 1'b1;
        step(); chk("rst_expire_e5", 3'b000);
        rst = 1'b0;
        for (int e = 6; e < 12; e++) begin
            step();
            chk($sformatf("rst_expire_e%0d", e), 3'b000);
        end

        // ---- Mid-count reset: press, rst at edge 3 for one cycle ----
        btn_in = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            chk($sformatf("midrst_e%0d", e), 3'b000);
        end
        rst = 1'b1;
        step(); chk("midrst_rst_e3", 3'b000);
        rst = 1'b0;
        // Counting restarts: first edge with rst low is edge 0 again.
        for (int e = 0; e < 5; e++) begin
            step();
            chk($sformatf("midrst_after_e%0d", e), 3'b000);
        end
        step(); chk("midrst_rise_e5", 3'b110);
        step(); chk("midrst_e6",      3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule : tb_btn_debounce
